// File: rtl/return_coin_dispenser.sv
// Greedy coin-return sequencer: ejects the largest fitting coin each cycle until the balance falls below the smallest coin.
// Optional idle-timeout auto-return is enabled by defining RETURN_TIMEOUT_EN.
`ifndef kTotalBits
`define kTotalBits 16
`endif
`ifndef kNumCoins
`define kNumCoins 3
`endif

module return_coin_dispenser #(
   parameter int unsigned COIN0_VALUE = 100,
   parameter int unsigned COIN1_VALUE = 500,
   parameter int unsigned COIN2_VALUE = 1000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [`kTotalBits-1:0]   current_total,
   input  logic                     i_trigger_return,
   input  logic                     i_activity,
   input  logic [31:0]              wait_time,
   output logic [`kNumCoins-1:0]    o_return_coin,
   output logic                     o_busy,
   output logic                     o_done
);

   localparam int unsigned TOTAL_BITS = `kTotalBits;
   localparam int unsigned NUM_COINS  = `kNumCoins;
   localparam int unsigned WAIT_BITS  = 32;

   localparam logic [TOTAL_BITS-1:0] C0 = TOTAL_BITS'(COIN0_VALUE);
   localparam logic [TOTAL_BITS-1:0] C1 = TOTAL_BITS'(COIN1_VALUE);
   localparam logic [TOTAL_BITS-1:0] C2 = TOTAL_BITS'(COIN2_VALUE);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPENSE = 2'd1,
      DONE     = 2'd2
   } state_t;

   state_t                  state, state_nxt;
   logic [TOTAL_BITS-1:0]   remaining, remaining_nxt;
   logic [TOTAL_BITS-1:0]   coin_val_c;
   logic [NUM_COINS-1:0]    coin_c;
   logic                    start_c;
   logic [WAIT_BITS-1:0]    wait_cnt, wait_nxt;

`ifdef RETURN_TIMEOUT_EN
   // Timeout fires on the edge that would take the counter to zero; activity defers it, a trigger never does.
   logic timeout_c;
   assign timeout_c = (current_total != '0) && (wait_cnt <= WAIT_BITS'(1));
   assign start_c   = i_trigger_return || (!i_activity && timeout_c);
`else
   logic unused_c;
   assign unused_c  = ^{wait_time, i_activity};
   assign start_c   = i_trigger_return;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         remaining <= '0;
         wait_cnt  <= wait_time;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         wait_cnt  <= wait_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      wait_nxt      = wait_cnt;
      coin_c        = '0;
      coin_val_c    = '0;
      o_busy        = 1'b0;
      o_done        = 1'b0;

      case (state)
         IDLE: begin
            if (start_c) begin
               if (current_total >= C0) begin
                  state_nxt     = DISPENSE;
                  remaining_nxt = current_total;
               end else begin
                  state_nxt     = DONE;
               end
`ifdef RETURN_TIMEOUT_EN
            end else if (i_activity) begin
               wait_nxt = wait_time;
            end else if ((current_total != '0) && (wait_cnt != '0)) begin
               wait_nxt = wait_cnt - WAIT_BITS'(1);
`endif
            end
         end

         DISPENSE: begin
            o_busy = 1'b1;
            // Greedy pick; the residual below the smallest coin stays in the machine.
            if (remaining >= C2) begin
               coin_c     = NUM_COINS'(3'b100);
               coin_val_c = C2;
            end else if (remaining >= C1) begin
               coin_c     = NUM_COINS'(3'b010);
               coin_val_c = C1;
            end else if (remaining >= C0) begin
               coin_c     = NUM_COINS'(3'b001);
               coin_val_c = C0;
            end
            remaining_nxt = remaining - coin_val_c;
            if (remaining_nxt < C0) begin
               state_nxt = DONE;
            end
         end

         DONE: begin
            o_done    = 1'b1;
            state_nxt = IDLE;
            wait_nxt  = wait_time;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      o_return_coin = coin_c;
   end

endmodule

// File: tb/tb_return_coin_dispenser.sv
// Scoreboard bench for return_coin_dispenser; timeout scenarios run when RETURN_TIMEOUT_EN is defined.
module tb_return_coin_dispenser;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] current_total = '0;
   logic        i_trigger_return = 1'b0;
   logic        i_activity = 1'b0;
   logic [31:0] wait_time = 32'd1000;
   logic [2:0]  o_return_coin;
   logic        o_busy;
   logic        o_done;

   int vectors = 0;
   int miscompares = 0;
   bit mon_en = 1'b0;

   // Entry layout: {busy, done, coin[2:0]}
   logic [4:0] exp_q[$];

   return_coin_dispenser dut (
      .clk              (clk),
      .reset            (reset),
      .current_total    (current_total),
      .i_trigger_return (i_trigger_return),
      .i_activity       (i_activity),
      .wait_time        (wait_time),
      .o_return_coin    (o_return_coin),
      .o_busy           (o_busy),
      .o_done           (o_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference greedy change-maker: expected coin stream followed by the done pulse.
   task automatic push_model(input int total);
      int rem = total;
      while (rem >= 100) begin
         if (rem >= 1000) begin
            exp_q.push_back(5'b10100);
            rem -= 1000;
         end else if (rem >= 500) begin
            exp_q.push_back(5'b10010);
            rem -= 500;
         end else begin
            exp_q.push_back(5'b10001);
            rem -= 100;
         end
      end
      exp_q.push_back(5'b01000);
   endtask

   always @(negedge clk) begin
      if (mon_en && (o_busy || o_done || (o_return_coin != 3'b000))) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", {27'd0, o_busy, o_done, o_return_coin}, 32'd0);
         end else begin
            logic [4:0] e;
            e = exp_q.pop_front();
            check("seq", {27'd0, o_busy, o_done, o_return_coin}, {27'd0, e});
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!o_done && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", {31'd0, o_done}, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic run_return(input int total);
      current_total = 16'(total);
      push_model(total);
      i_trigger_return = 1'b1;
      @(posedge clk); #1;
      i_trigger_return = 1'b0;
      @(negedge clk);
      check("start_latency", {31'd0, o_busy | o_done}, 32'd1);
      wait_done();
   endtask

   initial begin
      @(posedge clk); #1;
      do_reset();
      mon_en = 1'b1;
      check("rst_coin", {29'd0, o_return_coin}, 32'd0);
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      check("rst_done", {31'd0, o_done}, 32'd0);

      run_return(1600);
      run_return(50);
      run_return(700);
      run_return(1100);
      repeat (3) begin @(posedge clk); end #1;

      // Reset after the first coin aborts the sequence.
      current_total = 16'd2000;
      exp_q.push_back(5'b10100);
      i_trigger_return = 1'b1;
      @(posedge clk); #1;
      i_trigger_return = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_coin", {29'd0, o_return_coin}, 32'd0);
      check("abort_busy", {31'd0, o_busy}, 32'd0);
      check("abort_done", {31'd0, o_done}, 32'd0);
      repeat (5) begin @(posedge clk); end #1;
      check("abort_queue", exp_q.size(), 32'd0);

      // Trigger and activity held through dispense produce a single sequence.
      current_total = 16'd1600;
      push_model(1600);
      i_trigger_return = 1'b1;
      i_activity = 1'b1;
      repeat (3) begin @(posedge clk); end #1;
      i_trigger_return = 1'b0;
      i_activity = 1'b0;
      wait_done();
      repeat (5) begin @(posedge clk); end #1;
      check("no_retrigger", exp_q.size(), 32'd0);

`ifdef RETURN_TIMEOUT_EN
      // Auto-return on the 10th idle decrement.
      wait_time = 32'd10;
      current_total = 16'd700;
      push_model(700);
      do_reset();
      begin
         int n = 0;
         while (!o_busy && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("timeout_latency", n, 32'd11);
      end
      wait_done();
      current_total = 16'd0;
      repeat (3) begin @(posedge clk); end #1;

      // Periodic activity keeps the timeout from ever expiring.
      current_total = 16'd700;
      do_reset();
      for (int i = 0; i < 25; i++) begin
         i_activity = 1'b1;
         @(posedge clk); #1;
         i_activity = 1'b0;
         repeat (7) begin @(posedge clk); end #1;
      end
      check("activity_idle", exp_q.size(), 32'd0);
      i_activity = 1'b1;
      run_return(700);
      i_activity = 1'b0;
      current_total = 16'd0;
      repeat (3) begin @(posedge clk); end #1;

      // Zero reload value starts on the first idle cycle with a balance.
      wait_time = 32'd0;
      do_reset();
      current_total = 16'd150;
      push_model(150);
      @(posedge clk); #1;
      current_total = 16'd0;
      @(negedge clk);
      check("zero_wait_start", {29'd0, o_return_coin}, 32'd1);
      wait_done();
      repeat (5) begin @(posedge clk); end #1;
`else
      // Without the timeout, an idle balance is never returned.
      current_total = 16'd500;
      repeat (1000) begin @(posedge clk); end #1;
      check("idle_no_coin", exp_q.size(), 32'd0);
      run_return(500);
      repeat (3) begin @(posedge clk); end #1;
`endif

      check("final_queue", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
